// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: computes the next PC from a control opcode
// and keeps a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int                 ADDR_W    = 32,
    parameter int                 STEP      = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        op,
    input  logic              take,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_udf
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BR   = 3'b001,
        OP_JMP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } op_e;

    op_e               op_dec;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] next_pc;
    logic              do_push;
    logic              do_pop;
    logic              ovf_evt;
    logic              udf_evt;

    assign op_dec    = op_e'(op);
    assign pc_plus   = pc + STEP_V;
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_CNT);

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_pc = pc_plus;
        do_push = 1'b0;
        do_pop  = 1'b0;
        udf_evt = 1'b0;
        case (op_dec)
            OP_BR:   if (take) next_pc = pc + offset;
            OP_JMP:  next_pc = target;
            OP_CALL: begin
                next_pc = target;
                do_push = 1'b1;
            end
            OP_RET: begin
                if (ras_empty) begin
                    udf_evt = 1'b1;
                end else begin
                    next_pc = ras_mem[top_ptr];
                    do_pop  = 1'b1;
                end
            end
            default: ;  // undefined opcodes fall through as SEQ
        endcase
        ovf_evt = do_push && ras_full;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            top_ptr <= '0;
            count   <= '0;
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
        end else begin
            ras_ovf <= 1'b0;
            ras_udf <= 1'b0;
            if (!stall) begin
                pc      <= next_pc;
                ras_ovf <= ovf_evt;
                ras_udf <= udf_evt;
                if (do_push) begin
                    top_ptr <= top_ptr + PTR_ONE;
                    if (!ras_full) count <= count + CNT_ONE;
                end else if (do_pop) begin
                    top_ptr <= top_ptr - PTR_ONE;
                    count   <= count - CNT_ONE;
                end
            end
        end
    end

    // NOTE: stack storage is deliberately not reset; count and pointer define
    // validity, so the array can map onto plain flops or a small RAM.
    always_ff @(posedge clk) begin
        if (!stall && do_push) ras_mem[top_ptr + PTR_ONE] <= pc_plus;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with default parameters
// (32-bit PC, STEP=4, RESET_PC=0, 4-entry return-address stack).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic        take;
    logic [31:0] offset;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_udf;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JMP = 3'b010,
                           CALL = 3'b011, RET = 3'b100;

    typedef struct {
        logic        stall;
        logic [2:0]  op;
        logic        take;
        logic [31:0] offset;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .op        (op),
        .take      (take),
        .offset    (offset),
        .target    (target),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_udf   (ras_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    endtask

    task automatic add(input logic s, input logic [2:0] o, input logic t, input logic [31:0] off,
                       input logic [31:0] tgt, input logic [31:0] epc, input logic ee,
                       input logic ef, input logic eo, input logic eu);
        vec_t v;
        v.stall = s; v.op = o; v.take = t; v.offset = off; v.target = tgt;
        v.exp_pc = epc; v.exp_empty = ee; v.exp_full = ef; v.exp_ovf = eo; v.exp_udf = eu;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic [2:0] o, input logic t,
                         input logic [31:0] off, input logic [31:0] tgt);
        stall = s; op = o; take = t; offset = off; target = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] epc, input logic ee,
                               input logic ef, input logic eo, input logic eu);
        check({tag, " pc"},      pc,               epc);
        check({tag, " pc_plus"}, pc_plus,          epc + 32'd4);
        check({tag, " empty"},   32'(ras_empty),   32'(ee));
        check({tag, " full"},    32'(ras_full),    32'(ef));
        check({tag, " ovf"},     32'(ras_ovf),     32'(eo));
        check({tag, " udf"},     32'(ras_udf),     32'(eu));
    endtask

    initial begin
        // stall op take offset target | pc empty full ovf udf
        add(0, SEQ,    0, 0,            0,            32'h0000_0004, 1, 0, 0, 0);
        add(0, SEQ,    0, 0,            0,            32'h0000_0008, 1, 0, 0, 0);
        add(0, SEQ,    0, 0,            0,            32'h0000_000C, 1, 0, 0, 0);
        add(0, JMP,    0, 0,            32'h100,      32'h0000_0100, 1, 0, 0, 0);
        add(0, BR,     1, 32'hFFFF_FFF8, 0,           32'h0000_00F8, 1, 0, 0, 0);
        add(0, BR,     0, 32'hFFFF_FFF8, 0,           32'h0000_00FC, 1, 0, 0, 0);
        add(0, JMP,    0, 0,            32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0);
        add(0, SEQ,    0, 0,            0,            32'h0000_0000, 1, 0, 0, 0);
        add(0, 3'b101, 1, 32'h40,       32'h900,      32'h0000_0004, 1, 0, 0, 0);
        add(0, 3'b111, 1, 32'h40,       32'h900,      32'h0000_0008, 1, 0, 0, 0);
        add(0, JMP,    0, 0,            32'h40,       32'h0000_0040, 1, 0, 0, 0);
        add(0, CALL,   0, 0,            32'h200,      32'h0000_0200, 0, 0, 0, 0);
        add(0, SEQ,    0, 0,            0,            32'h0000_0204, 0, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_0044, 1, 0, 0, 0);
        // five nested calls: links 0x48, 0x1004, 0x2004, 0x3004, 0x4004
        add(0, CALL,   0, 0,            32'h1000,     32'h0000_1000, 0, 0, 0, 0);
        add(0, CALL,   0, 0,            32'h2000,     32'h0000_2000, 0, 0, 0, 0);
        add(0, CALL,   0, 0,            32'h3000,     32'h0000_3000, 0, 0, 0, 0);
        add(0, CALL,   0, 0,            32'h4000,     32'h0000_4000, 0, 1, 0, 0);
        add(0, CALL,   0, 0,            32'h5000,     32'h0000_5000, 0, 1, 1, 0);
        add(0, RET,    0, 0,            0,            32'h0000_4004, 0, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_3004, 0, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_2004, 0, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_1004, 1, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_1008, 1, 0, 0, 1);
        add(0, SEQ,    0, 0,            0,            32'h0000_100C, 1, 0, 0, 0);
        // stall holds everything while CALL is presented
        add(1, CALL,   0, 0,            32'h600,      32'h0000_100C, 1, 0, 0, 0);
        add(1, CALL,   0, 0,            32'h600,      32'h0000_100C, 1, 0, 0, 0);
        add(1, CALL,   0, 0,            32'h600,      32'h0000_100C, 1, 0, 0, 0);
        add(0, CALL,   0, 0,            32'h600,      32'h0000_0600, 0, 0, 0, 0);
        add(0, SEQ,    0, 0,            0,            32'h0000_0604, 0, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_1010, 1, 0, 0, 0);
        add(0, RET,    0, 0,            0,            32'h0000_1014, 1, 0, 0, 1);
        add(1, RET,    0, 0,            0,            32'h0000_1014, 1, 0, 0, 0);

        rst = 1'b1;
        stall = 1'b0; op = SEQ; take = 1'b0; offset = '0; target = '0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].op, vecs[i].take, vecs[i].offset, vecs[i].target);
            check_state($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_empty,
                        vecs[i].exp_full, vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // two entries stacked, then asynchronous reset between edges
        drive(0, CALL, 0, 0, 32'h700);
        check_state("pre_rst call1", 32'h700, 0, 0, 0, 0);
        drive(0, CALL, 0, 0, 32'h800);
        check_state("pre_rst call2", 32'h800, 0, 0, 0, 0);
        op = RET;
        #2;
        rst = 1'b1;
        #1;
        check_state("async_rst", 32'h0, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, RET, 0, 0, 0);
        check_state("post_rst ret", 32'h4, 1, 0, 0, 1);
        drive(0, SEQ, 0, 0, 0);
        check_state("post_rst seq", 32'h8, 1, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
